// File: rtl/round_sd.sv
// rtl/round_sd.sv - error-feedback requantiser from WIDTH_IN to WIDTH_OUT signed bits
module round_sd #(
  parameter int WIDTH_IN   = 18,
  parameter int WIDTH_OUT  = 16,
  parameter int DISABLE_SD = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic signed [WIDTH_IN-1:0]  in,
  input  logic                        strobe_in,
  output logic signed [WIDTH_OUT-1:0] out,
  output logic                        strobe_out
);

  localparam int S = WIDTH_IN - WIDTH_OUT;

  localparam logic [WIDTH_IN-1:0]  MAX_IN  = {1'b0, {(WIDTH_IN-1){1'b1}}};
  localparam logic [WIDTH_IN-1:0]  MIN_IN  = {1'b1, {(WIDTH_IN-1){1'b0}}};
  localparam logic [WIDTH_OUT-1:0] MAX_OUT = {1'b0, {(WIDTH_OUT-1){1'b1}}};
  localparam logic [WIDTH_OUT-1:0] MIN_OUT = {1'b1, {(WIDTH_OUT-1){1'b0}}};
  localparam logic [WIDTH_IN:0]    HALF    = (WIDTH_IN+1)'(1) << (S-1);

  logic [WIDTH_OUT-1:0] out_q, out_d;
  logic [S:0]           err_q, err_d;
  logic                 strobe_q, strobe_d;

  logic [WIDTH_IN:0]          sum_w;
  logic [WIDTH_IN-1:0]        sum_sat;
  logic [WIDTH_IN:0]          rnd;
  logic [WIDTH_IN:0]          q_full;
  logic [WIDTH_IN-WIDTH_OUT+1:0] q_hi;
  logic [WIDTH_OUT-1:0]       q_sat;
  logic [S:0]                 new_err;

  always_comb begin
    sum_w = {in[WIDTH_IN-1], in} + {{WIDTH_OUT{err_q[S]}}, err_q};
    if (sum_w[WIDTH_IN] != sum_w[WIDTH_IN-1]) begin
      sum_sat = sum_w[WIDTH_IN] ? MIN_IN : MAX_IN;
    end else begin
      sum_sat = sum_w[WIDTH_IN-1:0];
    end

    // Subtracting the sign bit turns floor-rounding of the half offset into ties-away-from-zero.
    rnd    = {sum_sat[WIDTH_IN-1], sum_sat} + HALF - {{WIDTH_IN{1'b0}}, sum_sat[WIDTH_IN-1]};
    q_full = $signed(rnd) >>> S;
    q_hi   = q_full[WIDTH_IN:WIDTH_OUT-1];
    if ((&q_hi) || !(|q_hi)) begin
      q_sat = q_full[WIDTH_OUT-1:0];
    end else begin
      q_sat = q_full[WIDTH_IN] ? MIN_OUT : MAX_OUT;
    end

    // Only the low S+1 bits of sum_sat - q*2^S are needed; the result is known to fit there.
    new_err = sum_sat[S:0] - {q_sat[0], {S{1'b0}}};

    out_d    = out_q;
    err_d    = err_q;
    strobe_d = 1'b0;
    if (strobe_in) begin
      out_d    = q_sat;
      err_d    = (DISABLE_SD != 0) ? '0 : new_err;
      strobe_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_q    <= '0;
      err_q    <= '0;
      strobe_q <= 1'b0;
    end else begin
      out_q    <= out_d;
      err_q    <= err_d;
      strobe_q <= strobe_d;
    end
  end

  assign out        = out_q;
  assign strobe_out = strobe_q;

endmodule

// File: tb/tb_round_sd.sv
// tb/tb_round_sd.sv - scoreboard bench for round_sd at 8->5 bits, with and without error feedback
module tb_round_sd;

  logic              clk = 1'b0;
  logic              rst;
  logic signed [7:0] in_s;
  logic              strobe_in;
  logic signed [4:0] out_a, out_b;
  logic              so_a, so_b;

  round_sd #(.WIDTH_IN(8), .WIDTH_OUT(5), .DISABLE_SD(0)) dut_sd (
    .clk(clk), .rst(rst), .in(in_s), .strobe_in(strobe_in), .out(out_a), .strobe_out(so_a));

  round_sd #(.WIDTH_IN(8), .WIDTH_OUT(5), .DISABLE_SD(1)) dut_plain (
    .clk(clk), .rst(rst), .in(in_s), .strobe_in(strobe_in), .out(out_b), .strobe_out(so_b));

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int exp_q[$];
  int exp_pq[$];
  int m_err = 0;
  int last_a = 0;
  int last_b = 0;

  function automatic void model(input int x, input int e, output int q, output int ne);
    int s;
    s = x + e;
    if (s > 127) s = 127;
    if (s < -128) s = -128;
    if (s >= 0) q = (s + 4) / 8;
    else        q = -((-s + 4) / 8);
    if (q > 15) q = 15;
    if (q < -16) q = -16;
    ne = s - q * 8;
  endfunction

  task automatic step(input int v, input bit stb, output int got);
    int q, ne, qp, dummy, ea, eb;
    in_s      = 8'(v);
    strobe_in = stb;
    if (stb) begin
      model(v, m_err, q, ne);
      m_err = ne;
      exp_q.push_back(q);
      model(v, 0, qp, dummy);
      exp_pq.push_back(qp);
    end
    @(posedge clk);
    #1;
    if (stb) begin
      ea = exp_q.pop_front();
      eb = exp_pq.pop_front();
      last_a = ea;
      last_b = eb;
    end else begin
      ea = last_a;
      eb = last_b;
    end
    checks++;
    if (so_a !== stb) begin
      errors++;
      $display("FAIL strobe_out_sd: got %0b expected %0b (in=%0d)", so_a, stb, v);
    end
    checks++;
    if (so_b !== stb) begin
      errors++;
      $display("FAIL strobe_out_plain: got %0b expected %0b (in=%0d)", so_b, stb, v);
    end
    checks++;
    if (int'(out_a) !== ea) begin
      errors++;
      $display("FAIL out_sd: got %0d expected %0d (in=%0d strobe=%0b)", out_a, ea, v, stb);
    end
    checks++;
    if (int'(out_b) !== eb) begin
      errors++;
      $display("FAIL out_plain: got %0d expected %0d (in=%0d strobe=%0b)", out_b, eb, v, stb);
    end
    got = int'(out_a);
  endtask

  task automatic do_reset();
    rst       = 1'b0;
    strobe_in = 1'b1;
    in_s      = 8'sd12;
    @(posedge clk);
    #1;
    rst    = 1'b1;
    m_err  = 0;
    last_a = 0;
    last_b = 0;
  endtask

  task automatic check_reset_state(input string tag);
    checks++;
    if (out_a !== 5'sd0 || so_a !== 1'b0) begin
      errors++;
      $display("FAIL %s_sd: got out=%0d strobe=%0b expected out=0 strobe=0", tag, out_a, so_a);
    end
    checks++;
    if (out_b !== 5'sd0 || so_b !== 1'b0) begin
      errors++;
      $display("FAIL %s_plain: got out=%0d strobe=%0b expected out=0 strobe=0", tag, out_b, so_b);
    end
  endtask

  task automatic test_pattern(input string tag, input int v, input int e0, input int e1,
                              input int e2, input int e3);
    int exp_seq[4];
    int got;
    exp_seq = '{e0, e1, e2, e3};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(v, 1'b1, got);
      checks++;
      if (got !== exp_seq[i % 4]) begin
        errors++;
        $display("FAIL %s[%0d]: got %0d expected %0d", tag, i, got, exp_seq[i % 4]);
      end
    end
  endtask

  task automatic test_reset();
    rst       = 1'b0;
    strobe_in = 1'b1;
    in_s      = 8'sd100;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("reset");
    rst = 1'b1;
    m_err = 0;
  endtask

  task automatic test_strobe_gap();
    int got;
    do_reset();
    for (int i = 0; i < 15; i++) begin
      step(12, (i % 3) == 0, got);
    end
  endtask

  task automatic test_reset_mid();
    int got;
    do_reset();
    step(10, 1'b1, got);
    step(10, 1'b1, got);
    rst       = 1'b0;
    strobe_in = 1'b1;
    in_s      = 8'sd10;
    @(posedge clk);
    #1;
    check_reset_state("reset_mid");
    rst    = 1'b1;
    m_err  = 0;
    last_a = 0;
    last_b = 0;
    step(10, 1'b1, got);
    checks++;
    if (got !== 1) begin
      errors++;
      $display("FAIL reset_mid_first: got %0d expected 1", got);
    end
  endtask

  task automatic test_ramp();
    int vals[10];
    int got, acc;
    vals = '{0, 5, 13, 29, 42, 60, 77, 99, 110, 120};
    do_reset();
    foreach (vals[k]) begin
      acc = 0;
      for (int i = 0; i < 64; i++) begin
        step(vals[k], 1'b1, got);
        acc += got;
        checks++;
        if (got * 8 - vals[k] > 8 || vals[k] - got * 8 > 8) begin
          errors++;
          $display("FAIL ramp_pm1: got %0d expected within 1 of %0d/8", got, vals[k]);
        end
      end
      checks++;
      if (acc - 8 * vals[k] > 1 || 8 * vals[k] - acc > 1) begin
        errors++;
        $display("FAIL ramp_mean: got sum %0d expected %0d +-1 (in=%0d)", acc, 8 * vals[k], vals[k]);
      end
    end
  endtask

  task automatic test_disable();
    int got;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      step(12, 1'b1, got);
      checks++;
      if (out_b !== 5'sd2) begin
        errors++;
        $display("FAIL disable_sd: got %0d expected 2", out_b);
      end
    end
  endtask

  task automatic test_back_to_back();
    int got;
    do_reset();
    for (int i = 0; i < 200; i++) begin
      step($urandom_range(0, 255) - 128, ($urandom_range(0, 3) != 0), got);
    end
  endtask

  initial begin
    rst       = 1'b0;
    strobe_in = 1'b0;
    in_s      = '0;
    test_reset();
    test_pattern("half_12", 12, 2, 1, 2, 1);
    test_pattern("quarter_10", 10, 1, 2, 1, 1);
    test_pattern("tie_pos4", 4, 1, 0, 1, 0);
    test_pattern("tie_neg4", -4, -1, 0, -1, 0);
    test_pattern("clip_pos", 127, 15, 15, 15, 15);
    test_pattern("clip_neg", -128, -16, -16, -16, -16);
    test_strobe_gap();
    test_reset_mid();
    test_ramp();
    test_disable();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/round_sd.md
# round_sd

Sigma-delta (error-feedback) requantiser that reduces a signed two's-complement sample stream from WIDTH_IN to WIDTH_OUT bits. Each input is summed with the quantisation error left over from the previous accepted sample, then rounded and saturated to the narrow width. Over many samples the output mean tracks the input divided by 2^(WIDTH_IN-WIDTH_OUT). It sits at the tail of DSP chains, feeding narrow DACs or buses, and carries a sample strobe through with one cycle of latency.

## Interface
- WIDTH_IN, 18: input width, signed; must satisfy WIDTH_IN > WIDTH_OUT.
- WIDTH_OUT, 16: output width, signed.
- DISABLE_SD, 0: when 1, the error feedback is forced to 0, giving plain round-to-nearest with saturation.

- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous, active-low.
- in  in  WIDTH_IN  signed input sample.
- strobe_in  in  1  in is valid this cycle.
- out  out  WIDTH_OUT  signed requantised sample.
- strobe_out  out  1  out was updated on this edge; strobe_in delayed by 1 cycle.

## Operation
- S = WIDTH_IN-WIDTH_OUT and E = S+1, the width of the signed error register err.
- On a cycle with strobe_in=1, compute the following combinationally:
  - sum = in + sign_extend(err), evaluated at WIDTH_IN+1 bits.
  - sum is saturated to the WIDTH_IN signed range [-2^(WIDTH_IN-1), 2^(WIDTH_IN-1)-1].
  - q = floor((sum + 2^(S-1) - (sum<0 ? 1 : 0)) / 2^S), evaluated at WIDTH_IN+1 bits. This is round-to-nearest with ties away from zero (+0.5 → 1, -0.5 → -1).
  - q is saturated to [-2^(WIDTH_OUT-1), 2^(WIDTH_OUT-1)-1].
  - new_err = sum_sat - q*2^S. This always fits in E signed bits; the worst case is +2^S-1 at positive clip.
- Registered on that edge: out <= q, err <= new_err (or 0 if DISABLE_SD=1), strobe_out <= 1.
- On a cycle with strobe_in=0: out and err hold their values, strobe_out <= 0.
- Error is carried only across strobed samples; idle cycles do not disturb the noise shaping.

## Timing
- Reset (rst=0 at an edge): out=0, err=0, strobe_out=0. Reset overrides strobe_in.
- The first strobed sample after reset sees err=0.
- Latency is 1 cycle: a sample presented with strobe_in at edge n appears on out, with strobe_out=1, after edge n.
- Throughput is one sample per cycle; strobe_in may be held high continuously.
- If reset is asserted mid-stream, the accumulated error is discarded and the next sample is treated as the first.
- There are no combinational paths from inputs to outputs.

## Test plan
All scenarios use WIDTH_IN=8, WIDTH_OUT=5 (scale factor 8) with strobe_in=1 continuously.
- in=12 (1.5) held → out alternates 2,1,2,1…; err alternates -4,0.
- in=10 (1.25) held → out repeats 1,2,1,1 (mean 1.25); err follows 2,-4,-2,0.
- in=4 → out 1,0,1,0…; in=-4 → out -1,0,-1,0… (ties away from zero).
- in=127 → out=15 every sample, err=7, no wrap to negative; in=-128 → out=-16, err=0.
- in=12 with strobe_in pulsed every 3rd cycle → out changes only after strobed edges, still 2,1,2…; strobe_out mirrors strobe_in one cycle later.
- Reset and ramp:
  - drop rst to 0 mid-stream → next edge gives out=0, strobe_out=0, and the error is cleared.
  - slow ramp of in from 0 upward, each value held 64 cycles → every out is within ±1 of in/8, and the average over each hold equals in/8 within 1/64.
  - with DISABLE_SD=1 and in=12 → out=2 constantly.
